// File: rtl/ax309_mbus.sv
// CPU-side request adapter for the 16 KiB ax309 on-chip RAM: decodes the RAM window,
// sequences the registered-address / delayed-write RAM timing and returns data with ready.
module ax309_mbus #(
  parameter logic [15:0] BASE = 16'h0000,
  parameter int unsigned WAIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_din,
  output logic        cpu_ready,
  output logic [13:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_we,
  input  logic [7:0]  mem_dout
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADR  = 3'd1,
    RDAT  = 3'd2,
    WADR  = 3'd3,
    WCOM  = 3'd4,
    WAITS = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam logic [2:0] W_LAST = 3'(WAIT - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_hit;
  logic [2:0]  r_cnt;
  logic [7:0]  r_din;
  logic        r_ready;
  logic [13:0] r_mem_addr;
  logic [7:0]  r_mem_din;
  logic        r_mem_we;

  logic        w_hit;
  logic        w_load;
  logic        w_we;
  logic        w_cap;
  logic        w_cnt_clr;
  logic        w_cnt_inc;

  assign w_hit = (cpu_addr[15:14] == BASE[15:14]);

  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_we      = 1'b0;
    w_cap     = 1'b0;
    w_cnt_clr = 1'b0;
    w_cnt_inc = 1'b0;
    case (r_state)
      IDLE: begin
        if (cpu_wr) begin
          w_next = WADR;
          w_load = 1'b1;
          w_we   = w_hit;
        end else if (cpu_rd) begin
          w_next = RADR;
          w_load = 1'b1;
        end
      end
      RADR: w_next = RDAT;
      RDAT: begin
        w_cap     = 1'b1;
        w_cnt_clr = 1'b1;
        w_next    = (WAIT == 0) ? DONE : WAITS;
      end
      WADR: w_next = WCOM;
      WCOM: begin
        w_cnt_clr = 1'b1;
        w_next    = (WAIT == 0) ? DONE : WAITS;
      end
      WAITS: begin
        if (r_cnt == W_LAST) w_next = DONE;
        else                 w_cnt_inc = 1'b1;
      end
      DONE: begin
        if (!cpu_rd && !cpu_wr) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Every output is a register; ready is raised on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_hit      <= 1'b0;
      r_cnt      <= 3'd0;
      r_din      <= 8'h00;
      r_ready    <= 1'b0;
      r_mem_addr <= 14'd0;
      r_mem_din  <= 8'h00;
      r_mem_we   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_mem_we <= w_we;
      r_ready  <= (w_next == DONE);
      if (w_load) begin
        r_mem_addr <= cpu_addr[13:0];
        r_mem_din  <= cpu_dout;
        r_hit      <= w_hit;
      end
      if (w_cap) r_din <= r_hit ? mem_dout : 8'hFF;
      if (w_cnt_clr)      r_cnt <= 3'd0;
      else if (w_cnt_inc) r_cnt <= r_cnt + 3'd1;
    end
  end

  assign cpu_din   = r_din;
  assign cpu_ready = r_ready;
  assign mem_addr  = r_mem_addr;
  assign mem_din   = r_mem_din;
  assign mem_we    = r_mem_we;

endmodule

// File: doc/ax309_mbus.md
Name: ax309_mbus

Overview:
- Bus adapter between the vm80a CPU-side request interface and the 16 KiB ax309 on-chip RAM.
- Decodes the RAM window out of the 64 KiB address space.
- Sequences the RAM's registered-address, delayed-write timing and returns read data with a ready handshake.
- Accesses outside the window complete as open bus.

Parameters:
- BASE, 16'h0000, start address of the RAM window; must be aligned to 16 KiB (BASE[13:0]==0).
- WAIT, 0, extra wait cycles (0..7) inserted before ready, for all accesses.

Ports:
- clk  in  1  system clock; also drives the RAM clka.
- rst  in  1  synchronous, active-high reset.
- cpu_addr  in  16  CPU address; stable while a request is held.
- cpu_dout  in  8  CPU write data; stable while cpu_wr is held.
- cpu_rd  in  1  read request level; held until cpu_ready is seen, then dropped.
- cpu_wr  in  1  write request level; same rules as cpu_rd.
- cpu_din  out  8  read data, registered; valid while cpu_ready=1.
- cpu_ready  out  1  access complete; stays high until the request is dropped.
- mem_addr  out  14  to RAM addra.
- mem_din  out  8  to RAM dina.
- mem_we  out  1  to RAM wea.
- mem_dout  in  8  from RAM douta, combinational from the RAM's registered address.

Behaviour:
- RAM model: the RAM samples addra/wea at each clk edge E. Data written at edge E+1 is dina at E+1. douta reflects the address latched at E, after E.
- Decode: hit = (cpu_addr[15:14] == BASE[15:14]); mem_addr = cpu_addr[13:0].
- Reset values: all outputs registered, and all are 0 during and after rst (cpu_din=8'h00, cpu_ready=0, mem_we=0, mem_addr=0, mem_din=0). FSM goes to IDLE.
- States: IDLE, RADR, RDAT, WADR, WCOM, WAITS, DONE.
- IDLE:
  - On cpu_wr, go to WADR. cpu_wr has priority if cpu_rd and cpu_wr are both high.
  - Else on cpu_rd, go to RADR.
  - Latch cpu_addr and cpu_dout into mem_addr/mem_din on entry.
- Read path:
  - RADR: RAM latches mem_addr at the end of this cycle.
  - RDAT: cpu_din <= hit ? mem_dout : 8'hFF at the end of this cycle.
  - Then go to WAITS.
- Write path:
  - WADR: mem_we=1 only if hit; mem_we=0 for a miss.
  - WCOM: mem_we=0; mem_din held; the RAM commits at the end of this cycle.
  - Then go to WAITS.
- WAITS: counts WAIT cycles (skipped when WAIT=0), then goes to DONE.
- DONE: cpu_ready=1. When both cpu_rd and cpu_wr are low, go to IDLE with cpu_ready=0 on the next cycle.
- Latency: with WAIT=0, cpu_ready rises in the 3rd cycle after the request is first sampled high; read and write are equal, hit or miss. Add WAIT cycles.
- mem_we rules:
  - Asserted for exactly one cycle per write hit; never asserted for misses or reads.
  - mem_addr and mem_din are stable from WADR through WCOM.
- Request dropped before ready (protocol violation): the access still completes. DONE exits immediately because the request is already low.
- Back-to-back: a new request is accepted only from IDLE, so at least one idle cycle separates accesses.
- Reset mid-operation:
  - Outputs are cleared on the next edge and the FSM returns to IDLE.
  - A write whose mem_we was already sampled by the RAM may still commit. This is acceptable; the adapter never issues a new write edge while rst=1.
- Reads of an address written in the immediately preceding access return the new data; no bypass is needed thanks to the idle gap.

Test Plan:
- Write, BASE=0, WAIT=0: cpu_wr with addr 16'h1234, data 8'hA5.
  - Required: mem_we high exactly 1 cycle with mem_addr=14'h1234.
  - Required: cpu_ready rises 3 cycles after the request; RAM[0x1234]=8'hA5.
- Read-back: cpu_rd at 16'h1234 after the above write.
  - Required: cpu_din=8'hA5 with cpu_ready on cycle 3.
  - Required: cpu_ready falls 1 cycle after cpu_rd drops.
- Miss, BASE=16'h4000: write 8'h3C to 16'h0010, then read 16'h0010.
  - Required: no mem_we pulse; read returns 8'hFF.
  - Required: RAM[0x0010] unchanged (preload 8'h11 and confirm it via a read at 16'h4010).
- Simultaneous cpu_rd=cpu_wr=1 at 16'h0100, data 8'h77.
  - Required: treated as a write; RAM[0x0100]=8'h77.
- WAIT=3: any read.
  - Required: cpu_ready in the 6th cycle.
  - Required: cpu_din stable until the request drops.
- Reset: assert rst during RDAT.
  - Required: cpu_ready=0, mem_we=0, cpu_din=0 the next cycle, FSM in IDLE.
  - Required: a following read of 16'h1234 completes normally with 8'hA5.
